// File: rtl/div_unit_if.sv
// Handshake/data bundle between the execute stage and the divider.
// master drives operands and control; slave returns result, ready and busy.
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic                start;
    logic                signed_div;
    logic                annul;
    logic [DATA_W-1:0]   dividend;
    logic [DATA_W-1:0]   divisor;
    logic [2*DATA_W-1:0] result;
    logic                ready;
    logic                busy;

    modport master (
        output start, signed_div, annul, dividend, divisor,
        input  result, ready, busy
    );

    modport slave (
        input  start, signed_div, annul, dividend, divisor,
        output result, ready, busy
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; result is {remainder, quotient}, ready DATA_W+1 cycles after start (2 for /0).
// No backpressure: busy stalls the pipeline, start outside IDLE is dropped, annul aborts to IDLE.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    div_unit_if.slave div_if
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, DIV_ZERO, DIV_ON, DIV_END} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     shifted, diff;
    logic [DATA_W-1:0]   rem_nxt, quot_nxt;

    // Magnitudes: 0x80000000 negates to itself and is then read as unsigned.
    assign a_neg = div_if.signed_div & div_if.dividend[DATA_W-1];
    assign b_neg = div_if.signed_div & div_if.divisor[DATA_W-1];
    assign a_mag = a_neg ? -div_if.dividend : div_if.dividend;
    assign b_mag = b_neg ? -div_if.divisor  : div_if.divisor;

    // quot_q starts as the dividend magnitude and is shifted out MSB-first into the remainder.
    assign shifted  = {rem_q, quot_q[DATA_W-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign rem_nxt  = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    assign quot_nxt = {quot_q[DATA_W-2:0], ~diff[DATA_W]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvs_d      = dvs_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    dvs_d      = b_mag;
                    quot_d     = a_mag;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    state_d    = (div_if.divisor == '0) ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: begin
                result_d = '0;
                state_d  = DIV_END;
            end
            DIV_ON: begin
                rem_d  = rem_nxt;
                quot_d = quot_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    result_d = {neg_rem_q  ? -rem_nxt  : rem_nxt,
                                neg_quot_q ? -quot_nxt : quot_nxt};
                    state_d  = DIV_END;
                end
            end
            DIV_END: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Flush wins over both a new start and completion.
        if (div_if.annul) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvs_q      <= dvs_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

    assign div_if.result = result_q;
    assign div_if.ready  = (state_q == DIV_END);
    assign div_if.busy   = (state_q == DIV_ZERO) || (state_q == DIV_ON);
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed test-plan cases plus randomized DIV/DIVU against a plain-arithmetic model.
module tb_div_unit;
    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    div_unit_if #(.DATA_W(32)) dif ();

    div_unit #(.DATA_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating integer division in 64-bit arithmetic; remainder follows the dividend's sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
        return (b == 32'd0) ? 1 : 32;
    endfunction

    // Issues one start pulse and waits (bounded) for ready; lat counts edges after the start edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] res, output int lat, output int busy_cycles);
        @(negedge clk);
        dif.dividend   = a;
        dif.divisor    = b;
        dif.signed_div = s;
        dif.start      = 1'b1;
        @(negedge clk);
        dif.start      = 1'b0;
        dif.dividend   = $urandom;
        dif.divisor    = $urandom;
        dif.signed_div = $urandom_range(0, 1);
        lat         = 0;
        busy_cycles = 0;
        while (!dif.ready && lat < 100) begin
            if (dif.busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        res = dif.result;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        dif.start      = 1'b0;
        dif.annul      = 1'b0;
        dif.signed_div = 1'b0;
        dif.dividend   = '0;
        dif.divisor    = '0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (dif.result !== 64'd0) begin err_cnt++; $display("FAIL reset_result: got %h expected 0", dif.result); end
        vec_cnt++;
        if (dif.ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b expected 0", dif.ready); end
        vec_cnt++;
        if (dif.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", dif.busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divu_basic();
        logic [63:0] res;
        int lat, bc;
        run_div(32'd100, 32'd7, 1'b0, res, lat, bc);
        vec_cnt++;
        if (res !== 64'h00000002_0000000E) begin err_cnt++; $display("FAIL divu_100_7: got %h expected 000000020000000e", res); end
        vec_cnt++;
        if (lat !== 32) begin err_cnt++; $display("FAIL divu_latency: got %0d expected 32", lat); end
        vec_cnt++;
        if (bc !== 32) begin err_cnt++; $display("FAIL divu_busy_cycles: got %0d expected 32", bc); end
        vec_cnt++;
        if (dif.busy !== 1'b0) begin err_cnt++; $display("FAIL busy_at_ready: got %b expected 0", dif.busy); end
        @(negedge clk);
        vec_cnt++;
        if (dif.ready !== 1'b0) begin err_cnt++; $display("FAIL ready_pulse_width: got %b expected 0", dif.ready); end
        vec_cnt++;
        if (dif.result !== 64'h00000002_0000000E) begin err_cnt++; $display("FAIL result_hold: got %h expected 000000020000000e", dif.result); end
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int lat, bc;
        run_div(32'hFFFFFFF9, 32'h00000002, 1'b1, res, lat, bc);
        vec_cnt++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) begin err_cnt++; $display("FAIL div_m7_2: got %h expected fffffffffffffffd", res); end
        run_div(32'h00000007, 32'hFFFFFFFE, 1'b1, res, lat, bc);
        vec_cnt++;
        if (res !== 64'h00000001_FFFFFFFD) begin err_cnt++; $display("FAIL div_7_m2: got %h expected 00000001fffffffd", res); end
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, res, lat, bc);
        vec_cnt++;
        if (res !== 64'h00000000_80000000) begin err_cnt++; $display("FAIL div_min_m1: got %h expected 0000000080000000", res); end
    endtask

    task automatic test_div_zero();
        logic [63:0] res;
        int lat, bc;
        run_div(32'd5, 32'd0, 1'b0, res, lat, bc);
        vec_cnt++;
        if (res !== 64'd0) begin err_cnt++; $display("FAIL divzero_result: got %h expected 0", res); end
        vec_cnt++;
        if (lat !== 1) begin err_cnt++; $display("FAIL divzero_latency: got %0d expected 1", lat); end
        vec_cnt++;
        if (bc !== 1) begin err_cnt++; $display("FAIL divzero_busy_cycles: got %0d expected 1", bc); end
    endtask

    task automatic test_annul();
        logic [63:0] prev, res;
        int lat, bc, rdy_seen;
        run_div(32'd77, 32'd5, 1'b0, prev, lat, bc);
        @(negedge clk);
        dif.dividend   = 32'hFFFFFFFF;
        dif.divisor    = 32'd3;
        dif.signed_div = 1'b0;
        dif.start      = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (10) @(negedge clk);
        dif.annul = 1'b1;
        @(negedge clk);
        dif.annul = 1'b0;
        vec_cnt++;
        if (dif.busy !== 1'b0) begin err_cnt++; $display("FAIL annul_idle: busy got %b expected 0", dif.busy); end
        vec_cnt++;
        if (dif.result !== prev) begin err_cnt++; $display("FAIL annul_result: got %h expected %h", dif.result, prev); end
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (dif.ready) rdy_seen++;
            @(negedge clk);
        end
        vec_cnt++;
        if (rdy_seen !== 0) begin err_cnt++; $display("FAIL annul_no_ready: got %0d ready cycles expected 0", rdy_seen); end
        run_div(32'd1000, 32'd10, 1'b0, res, lat, bc);
        vec_cnt++;
        if (res !== 64'h00000000_00000064) begin err_cnt++; $display("FAIL after_annul: got %h expected 0000000000000064", res); end
        vec_cnt++;
        if (lat !== 32) begin err_cnt++; $display("FAIL after_annul_latency: got %0d expected 32", lat); end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        dif.dividend   = 32'd100;
        dif.divisor    = 32'd7;
        dif.signed_div = 1'b0;
        dif.start      = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        lat = 0;
        while (!dif.ready && lat < 100) begin
            if (lat == 5) begin
                dif.dividend   = 32'd9;
                dif.divisor    = 32'd0;
                dif.signed_div = 1'b1;
                dif.start      = 1'b1;
            end else begin
                dif.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        dif.start = 1'b0;
        vec_cnt++;
        if (dif.result !== 64'h00000002_0000000E) begin err_cnt++; $display("FAIL ignore_start_result: got %h expected 000000020000000e", dif.result); end
        vec_cnt++;
        if (lat !== 32) begin err_cnt++; $display("FAIL ignore_start_latency: got %0d expected 32", lat); end
    endtask

    task automatic test_rst_mid();
        logic [63:0] res;
        int lat, bc;
        @(negedge clk);
        dif.dividend   = 32'hFFFFFFFF;
        dif.divisor    = 32'd7;
        dif.signed_div = 1'b0;
        dif.start      = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (dif.busy !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_busy: got %b expected 0", dif.busy); end
        vec_cnt++;
        if (dif.result !== 64'd0) begin err_cnt++; $display("FAIL rst_mid_result: got %h expected 0", dif.result); end
        vec_cnt++;
        if (dif.ready !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_ready: got %b expected 0", dif.ready); end
        @(negedge clk);
        rst_n = 1'b1;
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, res, lat, bc);
        vec_cnt++;
        if (res !== 64'h00000000_FFFFFFFF) begin err_cnt++; $display("FAIL after_rst: got %h expected 00000000ffffffff", res); end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        logic [63:0] res, exp;
        int lat, bc;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'(($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'd1);
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = model(a, b, s);
            run_div(a, b, s, res, lat, bc);
            vec_cnt++;
            if (res !== exp) begin err_cnt++; $display("FAIL rand_result a=%h b=%h s=%b: got %h expected %h", a, b, s, res, exp); end
            vec_cnt++;
            if (lat !== exp_lat(b)) begin err_cnt++; $display("FAIL rand_latency b=%h: got %0d expected %0d", b, lat, exp_lat(b)); end
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_ignore_start();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider that executes MIPS DIV and DIVU.
- Sits in the execute stage, directly upstream of the HI/LO register.
- The 64-bit result {remainder, quotient} drives the HI/LO register's hilo_i input. The ready pulse drives its write enable.
- busy stalls the pipeline while a division is in progress.

Parameters:
- DATA_W, 32, operand width. Result width is 2*DATA_W. Iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a division. Sampled only in IDLE.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- annul  in  1  flush: abort the current operation.
- dividend  in  DATA_W  operand A (rs).
- divisor  in  DATA_W  operand B (rt).
- result  out  2*DATA_W  {remainder, quotient}. Upper half goes to HI, lower half to LO.
- ready  out  1  one-cycle pulse: result valid, write HI/LO.
- busy  out  1  division in flight; pipeline stall request.

Behaviour:
Reset
- rst low, asynchronous: state=IDLE, counter=0, internal registers=0, result=0, ready=0, busy=0.

States
- IDLE, DIV_ZERO, DIV_ON, DIV_END.

IDLE
- If start=1 and annul=0 at an edge: latch dividend, divisor and signed_div. Inputs may change afterwards.
- Divisor equal to 0 → go to DIV_ZERO. Otherwise → go to DIV_ON with counter=0.

DIV_ZERO
- Next edge → DIV_END with result=0.

DIV_ON
- One restoring iteration per cycle on the magnitudes.
  - Shift the partial remainder left by one and subtract the divisor magnitude.
  - If the difference is non-negative, keep it and shift in quotient bit 1. Otherwise shift in 0.
- The counter increments each cycle. After DATA_W iterations, go to DIV_END with the corrected result registered.

DIV_END
- ready=1 for exactly this one cycle, then IDLE.
- result holds its value until the next start is accepted.

Timing
- Start sampled at edge 0 → ready high between edges 32 and 33.
- Divide-by-zero: ready high between edges 1 and 2.

busy
- busy = 1 in DIV_ZERO and DIV_ON. busy = 0 in IDLE and DIV_END, so the stall releases in the same cycle ready is asserted.

Signed handling
- Operands are converted to absolute values; the magnitude 0x80000000 is treated as unsigned.
- Quotient is negated if sign(A) xor sign(B).
- Remainder takes the sign of A.
- 0x80000000 / -1 gives quotient 0x80000000, remainder 0, with no trap.

Boundary rules
- start while not IDLE is ignored. No queuing.
- annul=1 in any state: next edge forces IDLE. ready is not asserted and result is unchanged.
- annul has priority over start and over completion.
- rst low mid-operation returns to the reset values immediately.

Test Plan:
- DIVU 100/7, start one cycle → busy for 32 cycles, ready at cycle 33, result=64'h00000002_0000000E.
- DIV -7/2 (0xFFFFFFF9/0x00000002) → result=64'hFFFFFFFF_FFFFFFFD. DIV 7/-2 → 64'h00000001_FFFFFFFD.
- DIVU 5/0 → ready two cycles after start, result=0. DIV 0x80000000/0xFFFFFFFF → 64'h00000000_80000000.
- annul asserted at cycle 10 of a DIVU 0xFFFFFFFF/3 → IDLE next cycle, no ready, result unchanged. A new start 1000/10 then gives 64'h00000000_00000064 at cycle 33.
- Operands changed and start re-pulsed during DIV_ON → ignored, and the original result is produced on schedule.
- rst driven low at cycle 15 between clock edges → outputs clear immediately. After release, DIVU 0xFFFFFFFF/1 → 64'h00000000_FFFFFFFF.
